// File: rtl/ym3438_pg_increment.sv
// ym3438_pg_increment
// Phase-generator increment pipeline: c1 hold latches feed a three-stage,
// c2-advanced pipeline computing (fnum << block) >> 1, detune, then multiply.
// Each result carries the slot index it entered with and its valid flag.

module ym3438_pg_increment (
   input  logic        MCLK,
   input  logic        IC,
   input  logic        c1,
   input  logic        c2,
   input  logic        sync,
   input  logic        in_valid,
   input  logic [10:0] fnum,
   input  logic [2:0]  block,
   input  logic [3:0]  multi,
   input  logic        dt_sign,
   input  logic [4:0]  dt_value,
   output logic [19:0] inc,
   output logic        inc_valid,
   output logic [4:0]  inc_slot
);

   // c2 wins when both phases coincide, so the latches only load on c1 alone
   logic load;
   assign load = c1 & ~c2;

   // hold latches
   logic [10:0] fnum_l;
   logic [2:0]  block_l;
   logic [3:0]  multi_l;
   logic        sync_l;
   logic        valid_l;
   logic        dt_sign_l;
   logic [4:0]  dt_value_l;

   // slot counter and pipeline registers
   logic [4:0]  cnt;
   logic [16:0] base1;
   logic [3:0]  multi1;
   logic        valid1;
   logic [4:0]  slot1;
   logic [16:0] det2;
   logic [3:0]  multi2;
   logic        valid2;
   logic [4:0]  slot2;

   // next-state values
   logic [4:0]  cnt_next;
   logic [16:0] base_next;
   logic [16:0] det_next;
   logic [19:0] prod;
   logic [19:0] inc_next;

   // next slot index: sync forces slot 0, otherwise count 0..23 and wrap
   always_comb begin
      // NOTE: default first so every path assigns and no latch is inferred
      cnt_next = cnt + 5'd1;
      if (sync_l || cnt == 5'd23)
         cnt_next = 5'd0;
   end

   // base = (fnum << block) >> 1, at most 11+6 = 17 bits, so it is exact
   always_comb begin
      base_next = {7'd0, fnum_l[10:1]};
      if (block_l != 3'd0)
         base_next = {6'd0, fnum_l} << (block_l - 3'd1);
   end

   // detune uses whatever sits in the dt latches at this advance, which is
   // one slot later than the operand now moving into stage 2
   always_comb begin
      det_next = base1 + {12'd0, dt_value_l};
      if (dt_sign_l)
         det_next = base1 - {12'd0, dt_value_l};
   end

   // multi = 0 means one half; otherwise multiply and keep the low 20 bits
   always_comb begin
      prod     = {3'd0, det2} * {16'd0, multi2};
      inc_next = prod;
      if (multi2 == 4'd0)
         inc_next = {4'd0, det2[16:1]};
   end

   // c1 hold latches
   always_ff @(posedge MCLK or negedge IC) begin
      if (!IC) begin
         fnum_l     <= '0;
         block_l    <= '0;
         multi_l    <= '0;
         sync_l     <= 1'b0;
         valid_l    <= 1'b0;
         dt_sign_l  <= 1'b0;
         dt_value_l <= '0;
      end else if (load) begin
         // NOTE: non-blocking so every register samples pre-edge values
         fnum_l     <= fnum;
         block_l    <= block;
         multi_l    <= multi;
         sync_l     <= sync;
         valid_l    <= in_valid;
         dt_sign_l  <= dt_sign;
         dt_value_l <= dt_value;
      end
   end

   // slot counter and the three pipeline stages, all advancing on c2
   always_ff @(posedge MCLK or negedge IC) begin
      if (!IC) begin
         cnt       <= '0;
         base1     <= '0;
         multi1    <= '0;
         valid1    <= 1'b0;
         slot1     <= '0;
         det2      <= '0;
         multi2    <= '0;
         valid2    <= 1'b0;
         slot2     <= '0;
         inc       <= '0;
         inc_valid <= 1'b0;
         inc_slot  <= '0;
      end else if (c2) begin
         cnt       <= cnt_next;
         base1     <= base_next;
         multi1    <= multi_l;
         valid1    <= valid_l;
         slot1     <= cnt_next;
         det2      <= det_next;
         multi2    <= multi1;
         valid2    <= valid1;
         slot2     <= slot1;
         inc       <= inc_next;
         inc_valid <= valid2;
         inc_slot  <= slot2;
      end
   end

endmodule

// File: tb/tb_ym3438_pg_increment.sv
// tb_ym3438_pg_increment
// Directed vectors with hand-computed increments and slot tags.

module tb_ym3438_pg_increment;

   logic        MCLK;
   logic        IC;
   logic        c1;
   logic        c2;
   logic        sync;
   logic        in_valid;
   logic [10:0] fnum;
   logic [2:0]  block;
   logic [3:0]  multi;
   logic        dt_sign;
   logic [4:0]  dt_value;
   logic [19:0] inc;
   logic        inc_valid;
   logic [4:0]  inc_slot;

   int n_total = 0;
   int n_bad   = 0;

   ym3438_pg_increment dut (
      .MCLK      (MCLK),
      .IC        (IC),
      .c1        (c1),
      .c2        (c2),
      .sync      (sync),
      .in_valid  (in_valid),
      .fnum      (fnum),
      .block     (block),
      .multi     (multi),
      .dt_sign   (dt_sign),
      .dt_value  (dt_value),
      .inc       (inc),
      .inc_valid (inc_valid),
      .inc_slot  (inc_slot)
   );

   initial MCLK = 1'b0;
   always #5 MCLK = ~MCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // one clock with the given phase enables; outputs sampled 1 ns after the edge
   task automatic tick(input logic c1v, input logic c2v);
      c1 = c1v;
      c2 = c2v;
      @(posedge MCLK);
      #1;
      c1 = 1'b0;
      c2 = 1'b0;
   endtask

   // one slot: latch on c1, then advance on c2
   task automatic slot_step();
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b1);
   endtask

   task automatic set_op(input logic [10:0] f, input logic [2:0] b, input logic [3:0] m,
                         input logic ds, input logic [4:0] dv, input logic v);
      fnum     = f;
      block    = b;
      multi    = m;
      dt_sign  = ds;
      dt_value = dv;
      in_valid = v;
   endtask

   int exp_cnt [0:63];
   bit sync_at;

   initial begin
      IC = 1'b0;
      c1 = 1'b0;
      c2 = 1'b0;
      sync = 1'b0;
      set_op(11'd0, 3'd0, 4'd0, 1'b0, 5'd0, 1'b0);
      repeat (3) @(posedge MCLK);
      #1;
      check("reset_inc",   inc,       32'h0);
      check("reset_valid", inc_valid, 32'h0);
      check("reset_slot",  inc_slot,  32'h0);
      IC = 1'b1;
      #2;

      // basic operand; first advance after reset gives slot 1
      set_op(11'h200, 3'd4, 4'd2, 1'b0, 5'd3, 1'b1);
      repeat (3) slot_step();
      check("basic_inc",   inc,       32'h02006);
      check("basic_valid", inc_valid, 32'h1);
      check("first_slot",  inc_slot,  32'h1);

      // detune underflow wraps to 0x1FFFF
      set_op(11'h000, 3'd0, 4'd15, 1'b1, 5'd1, 1'b1);
      repeat (3) slot_step();
      check("wrap_m15", inc, 32'hDFFF1);
      set_op(11'h000, 3'd0, 4'd0, 1'b1, 5'd1, 1'b1);
      repeat (3) slot_step();
      check("wrap_m0", inc, 32'h0FFFF);

      // largest base plus largest detune, no overflow
      set_op(11'h7FF, 3'd7, 4'd1, 1'b0, 5'd31, 1'b1);
      repeat (3) slot_step();
      check("max_inc", inc, 32'h1FFDF);

      // in_valid=0 operand still computed
      set_op(11'h200, 3'd4, 4'd2, 1'b0, 5'd3, 1'b0);
      repeat (3) slot_step();
      check("novalid_inc",   inc,       32'h02006);
      check("novalid_valid", inc_valid, 32'h0);

      // detune lag: A (base 0x100) picks up B's dt=5; B (base 8) picks up C's dt=0
      set_op(11'h100, 3'd1, 4'd1, 1'b0, 5'd0, 1'b1);
      slot_step();
      set_op(11'h010, 3'd0, 4'd1, 1'b0, 5'd5, 1'b1);
      slot_step();
      set_op(11'h000, 3'd0, 4'd1, 1'b0, 5'd0, 1'b1);
      slot_step();
      check("lag_a", inc, 32'h00105);
      slot_step();
      check("lag_b", inc, 32'h00008);

      // slot tags: sync at a=0, 30 and 54 (counter would read 23 before 54)
      exp_cnt[0] = 0;
      for (int a = 1; a < 58; a++)
         exp_cnt[a] = (a == 30 || a == 54) ? 0 : (exp_cnt[a-1] == 23 ? 0 : exp_cnt[a-1] + 1);
      check("cnt_before_sync", exp_cnt[53], 32'd23);
      for (int a = 0; a < 58; a++) begin
         sync_at = (a == 0 || a == 30 || a == 54);
         sync = sync_at;
         slot_step();
         sync = 1'b0;
         if (a >= 2)
            check($sformatf("slot_a%0d", a), inc_slot, exp_cnt[a-2]);
      end

      // async reset with three valid operands in flight
      set_op(11'h200, 3'd4, 4'd2, 1'b0, 5'd3, 1'b1);
      repeat (3) slot_step();
      check("pre_rst_valid", inc_valid, 32'h1);
      #2;
      IC = 1'b0;
      #1;
      check("rst_inc",   inc,       32'h0);
      check("rst_valid", inc_valid, 32'h0);
      check("rst_slot",  inc_slot,  32'h0);
      @(posedge MCLK);
      #2;
      IC = 1'b1;
      slot_step();
      check("post_rst_v1", inc_valid, 32'h0);
      slot_step();
      check("post_rst_v2", inc_valid, 32'h0);
      slot_step();
      check("post_rst_v3",   inc_valid, 32'h1);
      check("post_rst_inc",  inc,       32'h02006);
      check("post_rst_slot", inc_slot,  32'h1);

      // c1 with c2: latches must not load the new fnum/block/dt
      set_op(11'h200, 3'd4, 4'd2, 1'b0, 5'd3, 1'b1);
      tick(1'b1, 1'b0);
      set_op(11'h7FF, 3'd7, 4'd2, 1'b0, 5'd31, 1'b1);
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      check("c1c2_inc", inc, 32'h02006);
      tick(1'b0, 1'b1);
      check("c1c2_held_latch", inc, 32'h02006);

      // no c2: outputs hold while c1 keeps loading other values
      set_op(11'h001, 3'd0, 4'd0, 1'b1, 5'd9, 1'b0);
      repeat (4) tick(1'b1, 1'b0);
      repeat (3) tick(1'b0, 1'b0);
      check("hold_inc",   inc,       32'h02006);
      check("hold_valid", inc_valid, 32'h1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/ym3438_pg_increment.md
YM3438_PG_INCREMENT -- requirements
Module: ym3438_pg_increment

Interface
REQ-001 SHALL have port MCLK, input, 1 bit: the single master clock; all state changes on its rising edge.
REQ-002 SHALL have port IC, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port c1, input, 1 bit: phase-1 enable; input hold latches load on MCLK rise when c1=1.
REQ-004 SHALL have port c2, input, 1 bit: phase-2 enable; pipeline advances one slot on MCLK rise when c2=1.
REQ-005 SHALL have port sync, input, 1 bit: slot-0 marker, latched on c1.
REQ-006 SHALL have port in_valid, input, 1 bit: operand present, latched on c1.
REQ-007 SHALL have port fnum, input, 11 bits: frequency number.
REQ-008 SHALL have port block, input, 3 bits: octave.
REQ-009 SHALL have port multi, input, 4 bits: frequency multiplier.
REQ-010 SHALL have port dt_sign, input, 1 bit: detune direction, 1 = subtract.
REQ-011 SHALL have port dt_value, input, 5 bits: detune magnitude.
REQ-012 SHALL have port inc, output, 20 bits: phase increment.
REQ-013 SHALL have port inc_valid, output, 1 bit: inc carries a valid operand.
REQ-014 SHALL have port inc_slot, output, 5 bits: slot index (0..23) of inc.

Function
REQ-015 SHALL hold fnum, block, multi, sync, in_valid, dt_sign and dt_value in c1 hold latches; c1=0 holds the latches.
REQ-016 SHALL treat c1=1 with c2=1 in the same cycle as c2 only; latches do not load.
REQ-017 SHALL keep a slot counter: on each c2 advance it goes to 0 if latched sync=1, else counter+1, wrapping 23->0; sync has priority over wrap.
REQ-018 Stage 1 (c2 advance) SHALL register base = (fnum << block) >> 1, 17 bits exact, plus multi, in_valid and the new counter value as the slot tag.
REQ-019 Stage 2 (next c2) SHALL register det = base + dt_value (dt_sign=0) or base - dt_value (dt_sign=1), modulo 2^17, using the dt latch contents at that advance.
REQ-020 The dt latches SHALL therefore be applied to the operand that entered stage 1 one slot earlier, matching the one-slot lag of the detune source.
REQ-021 Stage 3 (next c2) SHALL register inc = det >> 1 when multi=0, else (det * multi) truncated to bits [19:0].
REQ-022 SHALL carry the slot tag and in_valid unchanged to inc_slot and inc_valid.
REQ-023 Latency: operand latched on c1 SHALL appear on inc at the third c2 advance after that latch.
REQ-024 With no c2 pulses, all pipeline state and outputs SHALL hold indefinitely.
REQ-025 in_valid=0 operands SHALL still be computed; only inc_valid marks them.

Reset
REQ-026 IC=0 SHALL immediately clear all latches, pipeline registers and the slot counter to 0, independent of MCLK.
REQ-027 During reset, inc=0, inc_valid=0 and inc_slot=0.
REQ-028 After IC deasserts, the first c2 advance without sync SHALL set the counter to 1.
REQ-029 Reset asserted mid-pipeline SHALL discard all in-flight operands; none reappear after release.

Verification
REQ-030 fnum=0x200, block=4, multi=2, dt_sign=0, dt_value=3 -> after three c2 advances: inc=0x02006, inc_valid=1.
REQ-031 fnum=0, block=0, dt_sign=1, dt_value=1, multi=15 -> det wraps to 0x1FFFF; inc=0xDFFF1. Same with multi=0 -> inc=0x0FFFF.
REQ-032 fnum=0x7FF, block=7, multi=1, dt_sign=0, dt_value=31 -> inc=0x1FFDF, with no overflow.
REQ-033 sync=1 on one slot, then 24 advances with sync=0 -> inc_slot follows 0,1..23,0; sync asserted at counter=23 -> next tag 0.
REQ-034 IC pulsed low with three valid operands in flight -> outputs 0 at once; after release inc_valid stays 0 until a new operand completes three advances.
REQ-035 c1 and c2 asserted together with new fnum -> latch unchanged; inc reflects the previous latch contents.
